instruction_fetch: RTL and testbench

Fetch stage between the program counter register and decode. Each cycle it computes next_address, which feeds the PC register's address input. The PC register loads that address unconditionally every clock, so this block holds the PC by returning it unchanged.
It issues word reads to instruction memory over a req/ack handshake and holds one fetched instruction for decode. It also handles branch redirects, interrupt entry and exception return.

---
 rtl/instruction_fetch.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the PC register's next address, runs one outstanding
// instruction-memory read at a time and holds a single fetched word for decode.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] INT_VECTOR = 32'd8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] next_address,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  decode_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  interrupt,
  input  logic                  eret,
  output logic                  int_ack,
  output logic [ADDR_WIDTH-1:0] epc
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    READY = 2'd1,
    WAIT  = 2'd2,
    KILL  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] imem_addr_reg, imem_addr_next;
  logic                  instr_valid_reg, instr_valid_next;
  logic [DATA_WIDTH-1:0] instr_reg, instr_next;
  logic [ADDR_WIDTH-1:0] instr_pc_reg, instr_pc_next;
  logic                  int_ack_reg, int_ack_next;
  logic [ADDR_WIDTH-1:0] epc_reg, epc_next;
  logic                  int_enable_reg, int_enable_next;

  logic slot_free;
  logic flow_change;

  assign slot_free   = !instr_valid_reg || decode_ready;
  assign flow_change = redirect || eret;

  always_comb begin
    state_next       = state_reg;
    imem_addr_next   = imem_addr_reg;
    instr_valid_next = instr_valid_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    int_ack_next     = 1'b0;
    epc_next         = epc_reg;
    int_enable_next  = int_enable_reg;
    next_address     = pc;

    if (instr_valid_reg && decode_ready) begin
      instr_valid_next = 1'b0;
    end

    // Redirect beats eret; both flush the held instruction in every running state.
    if (state_reg != BOOT) begin
      if (redirect) begin
        next_address     = redirect_target;
        instr_valid_next = 1'b0;
      end else if (eret) begin
        next_address     = epc_reg;
        int_enable_next  = 1'b1;
        instr_valid_next = 1'b0;
      end
    end

    case (state_reg)
      BOOT: begin
        if (redirect) begin
          next_address = redirect_target;
        end
        state_next = READY;
      end
      READY: begin
        if (!flow_change) begin
          if (interrupt && int_enable_reg && !instr_valid_reg) begin
            next_address    = INT_VECTOR;
            epc_next        = pc;
            int_enable_next = 1'b0;
            int_ack_next    = 1'b1;
          end else if (slot_free) begin
            imem_addr_next = pc;
            next_address   = pc + ONE;
            state_next     = WAIT;
          end
        end
      end
      WAIT: begin
        if (flow_change) begin
          state_next = imem_ack ? READY : KILL;
        end else if (imem_ack) begin
          instr_next       = imem_rdata;
          instr_pc_next    = imem_addr_reg;
          instr_valid_next = 1'b1;
          state_next       = READY;
        end
      end
      KILL: begin
        // The read must complete before a new one may start; its data is dropped.
        if (imem_ack) begin
          state_next = READY;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= BOOT;
      imem_addr_reg   <= '0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
      int_ack_reg     <= 1'b0;
      epc_reg         <= '0;
      int_enable_reg  <= 1'b1;
    end else begin
      state_reg       <= state_next;
      imem_addr_reg   <= imem_addr_next;
      instr_valid_reg <= instr_valid_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
      int_ack_reg     <= int_ack_next;
      epc_reg         <= epc_next;
      int_enable_reg  <= int_enable_next;
    end
  end

  assign imem_req    = (state_reg == WAIT) || (state_reg == KILL);
  assign imem_addr   = imem_addr_reg;
  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign int_ack     = int_ack_reg;
  assign epc         = epc_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: models the PC register and a variable-latency
// memory; a negedge monitor checks fetches, deliveries and int_ack against queues.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] next_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        decode_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        interrupt = 1'b0;
  logic        eret = 1'b0;
  logic        int_ack;
  logic [31:0] epc;

  int n_cmp = 0;
  int n_bad = 0;
  int mem_lat = 1;
  int wait_cnt = 0;
  bit req_open = 1'b0;

  logic [31:0] exp_fetch[$];
  logic [63:0] exp_instr[$];
  logic [31:0] exp_int[$];

  instruction_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INT_VECTOR(32'd8)) dut (
    .clock(clock), .reset(reset), .pc(pc), .next_address(next_address),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .decode_ready(decode_ready), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .redirect(redirect),
    .redirect_target(redirect_target), .interrupt(interrupt), .eret(eret),
    .int_ack(int_ack), .epc(epc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h20080005;
    return a ^ 32'hA5A50000;
  endfunction

  // PC register: loads next_address every clock, never reset.
  always @(posedge clock) pc <= next_address;

  // Memory: acks once the request has been open for mem_lat cycles.
  always @(posedge clock) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 30; i++) begin
      if (instr_valid) return;
      tick();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: instr_valid never rose, got 0 expected 1", name);
  endtask

  task automatic wait_ack(input string name);
    for (int i = 0; i < 30; i++) begin
      if (imem_ack) return;
      tick();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: imem_ack never rose, got 0 expected 1", name);
  endtask

  // Monitor: every new request, delivered instruction and int_ack pulse is matched in order.
  always @(negedge clock) begin
    if (imem_req && !req_open) begin
      req_open = 1'b1;
      if (exp_fetch.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL fetch_unexpected: got addr %h, expected no request", imem_addr);
      end else begin
        check("fetch_addr", imem_addr, exp_fetch.pop_front());
      end
    end
    if (imem_ack || !imem_req) req_open = 1'b0;
    if (instr_valid && decode_ready) begin
      if (exp_instr.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL instr_unexpected: got pc %h instr %h, expected none", instr_pc, instr);
      end else begin
        check("deliver", {instr_pc, instr}, exp_instr.pop_front());
      end
    end
    if (int_ack) begin
      if (exp_int.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL int_ack_unexpected: got 1, expected 0");
      end else begin
        check("int_epc", epc, exp_int.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_int_ack", int_ack, 0);
    check("rst_epc", epc, 0);
    check("rst_next_address", next_address, pc);

    // Boot then first fetch
    reset = 1'b1;
    exp_fetch.push_back(32'd0);
    exp_instr.push_back({32'd0, 32'h20080005});
    check("boot_no_req", imem_req, 0);
    tick();
    check("ready_launch_next", next_address, 32'd1);
    tick();
    check("wait_req", imem_req, 1);
    check("wait_addr", imem_addr, 32'd0);
    wait_valid("first_fill");
    check("fill_instr", instr, 32'h20080005);
    check("fill_instr_pc", instr_pc, 32'd0);

    // Decode stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      check("stall_no_req", imem_req, 0);
      check("stall_hold_pc", next_address, pc);
      check("stall_instr", instr, 32'h20080005);
      tick();
    end
    decode_ready = 1'b1;
    exp_fetch.push_back(32'd1);
    exp_instr.push_back({32'd1, mem_word(32'd1)});
    #1;
    check("unstall_launch", next_address, 32'd2);
    tick();
    decode_ready = 1'b0;
    wait_valid("fill_1");

    // Redirect in the first WAIT cycle -> KILL, late data discarded
    mem_lat = 3;
    decode_ready = 1'b1;
    exp_fetch.push_back(32'd2);
    exp_fetch.push_back(32'h40);
    #1;
    check("launch_2", next_address, 32'd3);
    tick();
    decode_ready = 1'b0;
    redirect = 1'b1;
    redirect_target = 32'h40;
    #1;
    check("kill_redirect_next", next_address, 32'h40);
    check("kill_instr_valid", instr_valid, 0);
    tick();
    redirect = 1'b0;
    check("kill_req_held", imem_req, 1);
    check("kill_addr_stable", imem_addr, 32'd2);
    wait_ack("kill_ack");
    check("kill_hold_pc", next_address, 32'h40);
    mem_lat = 1;
    tick();
    check("kill_dropped", instr_valid, 0);
    check("launch_40", next_address, 32'h41);
    tick();

    // Redirect coincident with ack -> data dropped, READY
    wait_ack("redir_ack");
    redirect = 1'b1;
    redirect_target = 32'h10;
    #1;
    check("ack_redirect_next", next_address, 32'h10);
    tick();
    redirect = 1'b0;
    exp_fetch.push_back(32'h10);
    exp_instr.push_back({32'h10, mem_word(32'h10)});
    #1;
    check("ack_redirect_valid", instr_valid, 0);
    check("ack_redirect_ready", imem_req, 0);
    check("launch_10", next_address, 32'h11);
    tick();
    wait_valid("fill_10");

    // Interrupt entry from pc 0x15 with the slot empty
    decode_ready = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h15;
    #1;
    check("redirect_15", next_address, 32'h15);
    tick();
    redirect = 1'b0;
    decode_ready = 1'b0;
    interrupt = 1'b1;
    exp_int.push_back(32'h15);
    #1;
    check("int_vector", next_address, 32'd8);
    tick();
    check("int_ack_pulse", int_ack, 1);
    check("int_epc_direct", epc, 32'h15);
    exp_fetch.push_back(32'd8);
    exp_instr.push_back({32'd8, mem_word(32'd8)});
    check("launch_8", next_address, 32'd9);
    tick();
    check("int_ack_one_cycle", int_ack, 0);
    wait_valid("fill_8");
    for (int i = 0; i < 3; i++) begin
      check("int_masked", int_ack, 0);
      tick();
    end

    // eret returns to epc and re-enables the interrupt
    decode_ready = 1'b1;
    eret = 1'b1;
    #1;
    check("eret_next", next_address, 32'h15);
    tick();
    eret = 1'b0;
    decode_ready = 1'b0;
    exp_int.push_back(32'h15);
    #1;
    check("int_retaken", next_address, 32'd8);
    tick();
    interrupt = 1'b0;
    check("int_ack_again", int_ack, 1);
    mem_lat = 10;
    exp_fetch.push_back(32'd8);
    tick();
    tick();

    // Asynchronous reset in the middle of WAIT
    check("pre_reset_req", imem_req, 1);
    #3;
    reset = 1'b0;
    #1;
    check("async_req", imem_req, 0);
    check("async_valid", instr_valid, 0);
    check("async_instr", instr, 0);
    check("async_addr", imem_addr, 0);
    check("async_epc", epc, 0);
    mem_lat = 1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_fetch.push_back(32'd9);
    exp_instr.push_back({32'd9, mem_word(32'd9)});
    tick();
    check("reboot_launch", next_address, 32'd10);
    tick();
    wait_valid("fill_9");

    // Redirect beats simultaneous eret; pc+1 wraps to zero
    decode_ready = 1'b1;
    redirect = 1'b1;
    eret = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    #1;
    check("redirect_over_eret", next_address, 32'hFFFF_FFFF);
    tick();
    redirect = 1'b0;
    eret = 1'b0;
    decode_ready = 1'b0;
    exp_fetch.push_back(32'hFFFF_FFFF);
    exp_instr.push_back({32'hFFFF_FFFF, mem_word(32'hFFFF_FFFF)});
    #1;
    check("wrap_next", next_address, 32'd0);
    tick();
    wait_valid("fill_wrap");
    decode_ready = 1'b1;
    exp_fetch.push_back(32'd0);
    #1;
    check("launch_0", next_address, 32'd1);
    tick();
    decode_ready = 1'b0;
    wait_valid("fill_0");
    check("final_instr", instr, 32'h20080005);
    check("final_instr_pc", instr_pc, 32'd0);
    repeat (3) tick();
    check("fetch_queue_drained", exp_fetch.size(), 0);
    check("instr_queue_drained", exp_instr.size(), 0);
    check("int_queue_drained", exp_int.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
